// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one clocked single-port memory between the
// asynchronous 4-phase load and store channels of the load/store path.
module lsu_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_req,
  input  logic [ADDR_W-1:0]     ld_addr,
  output logic                  ld_ack,
  output logic [DATA_W-1:0]     ld_rdata,
  input  logic                  st_req,
  input  logic [ADDR_W-1:0]     st_addr,
  input  logic [DATA_W-1:0]     st_wdata,
  input  logic [DATA_W/8-1:0]   st_be,
  output logic                  st_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] ACK     = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [SYNC_STAGES-1:0] ld_sync_reg;
  logic [SYNC_STAGES-1:0] st_sync_reg;
  logic                   ld_s;
  logic                   st_s;

  logic [1:0]             state_reg;
  logic                   last_grant_st_reg;
  logic                   grant_st_reg;
  logic                   pick_st;
  logic                   granted_s;

  logic                   mem_req_reg;
  logic                   mem_we_reg;
  logic [ADDR_W-1:0]      mem_addr_reg;
  logic [DATA_W-1:0]      mem_wdata_reg;
  logic [BE_W-1:0]        mem_be_reg;
  logic                   ld_ack_reg;
  logic                   st_ack_reg;
  logic [DATA_W-1:0]      ld_rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_sync_reg <= '0;
      st_sync_reg <= '0;
    end else begin
      ld_sync_reg <= {ld_sync_reg[SYNC_STAGES-2:0], ld_req};
      st_sync_reg <= {st_sync_reg[SYNC_STAGES-2:0], st_req};
    end
  end

  assign ld_s = ld_sync_reg[SYNC_STAGES-1];
  assign st_s = st_sync_reg[SYNC_STAGES-1];

  // Store wins only when it is the sole requester or load was served last.
  assign pick_st   = st_s & (~ld_s | ~last_grant_st_reg);
  assign granted_s = grant_st_reg ? st_s : ld_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      last_grant_st_reg <= 1'b1;
      grant_st_reg      <= 1'b0;
      mem_req_reg       <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
      mem_be_reg        <= '0;
      ld_ack_reg        <= 1'b0;
      st_ack_reg        <= 1'b0;
      ld_rdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ld_s || st_s) begin
            grant_st_reg      <= pick_st;
            last_grant_st_reg <= pick_st;
            mem_req_reg       <= 1'b1;
            state_reg         <= ACCESS;
            if (pick_st) begin
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= st_addr;
              mem_wdata_reg <= st_wdata;
              mem_be_reg    <= st_be;
            end else begin
              mem_we_reg    <= 1'b0;
              mem_addr_reg  <= ld_addr;
              mem_wdata_reg <= '0;
              mem_be_reg    <= '1;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_req_reg <= 1'b0;
            state_reg   <= ACK;
            if (grant_st_reg) begin
              st_ack_reg <= 1'b1;
            end else begin
              ld_ack_reg   <= 1'b1;
              ld_rdata_reg <= mem_rdata;
            end
          end
        end
        ACK: begin
          // Four-phase return: hold ack until the requester's req is seen low.
          if (!granted_s) begin
            ld_ack_reg <= 1'b0;
            st_ack_reg <= 1'b0;
            state_reg  <= RELEASE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign ld_ack    = ld_ack_reg;
  assign st_ack    = st_ack_reg;
  assign ld_rdata  = ld_rdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: single load/store, contention,
// fairness, reset mid-access and spurious mem_ready.
module tb_lsu_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_req = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;
  logic              st_req = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_wdata = '0;
  logic [3:0]        st_be = '0;
  logic              st_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int both_ack_cnt = 0;

  lsu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
    .st_ack(st_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ld_ack && st_ack) both_ack_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_mem_req(input string tag);
    for (int k = 0; k < 20 && !mem_req; k++) step();
    check(tag, mem_req, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && busy; k++) step();
    check(tag, busy, 0);
  endtask

  initial begin
    // Reset state
    step();
    do_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_acks", {ld_ack, st_ack}, 0);
    check("rst_busy", busy, 0);
    check("rst_ld_rdata", ld_rdata, 0);

    // Single load, zero-wait memory
    ld_addr = 32'h100; ld_req = 1'b1; mem_rdata = 32'hDEADBEEF; mem_ready = 1'b1;
    step();
    check("ld_e1_mem_req", mem_req, 0);
    step();
    check("ld_e2_mem_req", mem_req, 0);
    step();
    check("ld_e3_mem_req", mem_req, 1);
    check("ld_e3_fields", {mem_we, mem_be, mem_addr}, {1'b0, 4'hF, 32'h100});
    check("ld_e3_wdata", mem_wdata, 0);
    check("ld_e3_busy", busy, 1);
    step();
    check("ld_e4_acks", {ld_ack, st_ack}, 2'b10);
    check("ld_e4_rdata", ld_rdata, 32'hDEADBEEF);
    check("ld_e4_mem_req", mem_req, 0);
    mem_ready = 1'b0; ld_req = 1'b0;
    step();
    check("ld_rel1_ack", ld_ack, 1);
    step();
    check("ld_rel2_ack", ld_ack, 1);
    step();
    check("ld_rel3_ack", ld_ack, 0);
    check("ld_rel3_busy", busy, 1);
    step();
    check("ld_idle_busy", busy, 0);

    // Single store with three wait cycles
    st_addr = 32'h200; st_wdata = 32'h12345678; st_be = 4'h3; st_req = 1'b1;
    mem_rdata = 32'h0BADF00D;
    step(); step(); step();
    for (int c = 0; c < 3; c++) begin
      check("st_wait_req", mem_req, 1);
      check("st_wait_fields", {mem_we, mem_be, mem_addr}, {1'b1, 4'h3, 32'h200});
      check("st_wait_wdata", mem_wdata, 32'h12345678);
      step();
    end
    check("st_last_req", mem_req, 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("st_acks", {ld_ack, st_ack}, 2'b01);
    check("st_mem_req_low", mem_req, 0);
    check("st_ld_rdata_kept", ld_rdata, 32'hDEADBEEF);
    st_req = 1'b0;
    step(); step(); step();
    check("st_ack_fall", st_ack, 0);
    step();

    // Spurious mem_ready in IDLE
    mem_rdata = 32'hBAD0BAD0; mem_ready = 1'b1;
    step(); step();
    check("spur_acks", {ld_ack, st_ack}, 0);
    check("spur_rdata", ld_rdata, 32'hDEADBEEF);
    check("spur_busy", busy, 0);
    mem_ready = 1'b0;

    // Simultaneous requests from reset: load first, then store
    do_reset();
    ld_addr = 32'h300; st_addr = 32'h400; st_be = 4'hC; st_wdata = 32'hCAFE0000;
    mem_rdata = 32'h11112222; mem_ready = 1'b1;
    ld_req = 1'b1; st_req = 1'b1;
    step(); step(); step();
    check("sim_first_grant", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h300});
    step();
    check("sim_ld_ack", {ld_ack, st_ack}, 2'b10);
    check("sim_ld_rdata", ld_rdata, 32'h11112222);
    ld_req = 1'b0;
    step(); step(); step();
    check("sim_ld_ack_fall", ld_ack, 0);
    step();
    check("sim_idle_no_req", mem_req, 0);
    step();
    check("sim_second_grant", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b1, 4'hC, 32'h400});
    step();
    check("sim_st_ack", {ld_ack, st_ack}, 2'b01);
    st_req = 1'b0;
    wait_idle("sim_done_idle");

    // Persistent contention: strict alternation L,S,L,S,L,S
    do_reset();
    mem_ready = 1'b1;
    ld_req = 1'b1; st_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_mem_req("cont_req_seen");
      check("cont_grant_we", mem_we, (i % 2));
      step();
      if (i % 2 == 0) begin
        check("cont_ld_ack", {ld_ack, st_ack}, 2'b10);
        ld_req = 1'b0;
      end else begin
        check("cont_st_ack", {ld_ack, st_ack}, 2'b01);
        st_req = 1'b0;
      end
      wait_idle("cont_release");
      if (i < 5) begin
        if (i % 2 == 0) ld_req = 1'b1;
        else st_req = 1'b1;
      end
    end
    ld_req = 1'b0; st_req = 1'b0;
    for (int k = 0; k < 12; k++) step();
    check("never_both_acks", both_ack_cnt, 0);

    // Reset mid-access; held store req is re-served afterwards
    do_reset();
    mem_ready = 1'b0;
    st_addr = 32'h600; st_be = 4'hF; st_wdata = 32'h600DF00D; st_req = 1'b1;
    wait_mem_req("rma_req_seen");
    step(); step();
    check("rma_still_access", {mem_req, busy}, 2'b11);
    rst = 1'b1;
    step();
    check("rma_after_rst", {mem_req, ld_ack, st_ack, busy}, 4'b0000);
    rst = 1'b0;
    step(); step();
    check("rma_resync_no_req", mem_req, 0);
    step();
    check("rma_regrant", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h600});
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("rma_st_ack", {ld_ack, st_ack}, 2'b01);
    st_req = 1'b0;
    wait_idle("rma_done_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
